servo_move_arbiter: RTL and testbench

//  Owns the single x-axis servo position register; shares it between the manual requester (switches)
//  and the automatic requester (target-seek), which are otherwise independent.

---
 rtl/servo_pkg.sv | 49 ++++
 rtl/servo_step_timer.sv | 28 ++
 rtl/servo_move_arbiter.sv | 114 +++++++++++
 tb/tb_servo_move_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types for the servo move arbiter: FSM state encoding, seek direction and default step size.
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAN_L = 3'd1,
        MAN_R = 3'd2,
        SEEK  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int STEP_DEFAULT = 3;

    // Manual requester always wins; a seek only starts from IDLE with manual released.
    function automatic state_t next_state(
        input state_t s,
        input logic   manual,
        input logic   sw1,
        input logic   sw2,
        input logic   auto_req,
        input logic   at_target
    );
        state_t n;
        logic   go_l;
        logic   go_r;
        go_l = manual && sw1 && !sw2;
        go_r = manual && sw2 && !sw1;
        n    = s;
        case (s)
            IDLE: begin
                if (go_l)                     n = MAN_L;
                else if (go_r)                n = MAN_R;
                else if (!manual && auto_req) n = SEEK;
            end
            MAN_L, MAN_R: n = go_l ? MAN_L : (go_r ? MAN_R : IDLE);
            SEEK: begin
                if (manual)         n = IDLE;
                else if (at_target) n = DONE;
            end
            DONE:    n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/servo_step_timer.sv
// Step pacing timer: one tick every STEP_TICKS cycles while run is high; clear restarts the count.
module servo_step_timer #(
    parameter int STEP_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // A tick coinciding with a state change is swallowed so the exit cycle never moves the servo.
    assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/servo_move_arbiter.sv
// Owns the x-axis servo position and shares it between manual switches and an automatic target seek.
// Build option SERVO_LIMIT_EN: saturate manual moves and clamp seek targets to [POS_MIN, POS_MAX].
module servo_move_arbiter
    import servo_pkg::*;
#(
    parameter int POS_W      = 8,
    parameter int STEP       = STEP_DEFAULT,
    parameter int STEP_TICKS = 4,
    parameter int POS_INIT   = 90,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             manual,
    input  logic             i_Switch_1,
    input  logic             i_Switch_2,
    input  logic             auto_req,
    input  logic [POS_W-1:0] auto_target,
    output logic             auto_ack,
    output logic             auto_abort,
    output logic             busy,
    output logic [POS_W-1:0] x_position
);

    localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);

    // Auto handshake: auto_req is a level sampled only in IDLE; acceptance latches auto_target.
    // The seek then ends in exactly one of a one-cycle auto_ack (reached) or auto_abort (manual took over).
    state_t           state;
    state_t           nxt;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] target_in;
    logic [POS_W-1:0] man_left;
    logic [POS_W-1:0] man_right;
    logic [POS_W-1:0] seek_dist;
    logic [POS_W-1:0] seek_step;
    logic             seek_dir;
    logic             state_change;
    logic             timer_run;
    logic             step_tick;

    always_comb begin
        nxt          = next_state(state, manual, i_Switch_1, i_Switch_2, auto_req,
                                  x_position == target);
        state_change = (nxt != state);
        timer_run    = (state == MAN_L) || (state == MAN_R) || (state == SEEK);
    end

    always_comb begin
        seek_dir  = (target > x_position) ? DIR_RIGHT : DIR_LEFT;
        seek_dist = (seek_dir == DIR_RIGHT) ? target - x_position : x_position - target;
        seek_step = (seek_dist < STEP_V) ? seek_dist : STEP_V;
    end

`ifdef SERVO_LIMIT_EN
    always_comb begin
        man_left  = (int'(x_position) < POS_MIN + STEP) ? POS_W'(POS_MIN) : x_position - STEP_V;
        man_right = (int'(x_position) > POS_MAX - STEP) ? POS_W'(POS_MAX) : x_position + STEP_V;
        if (int'(auto_target) > POS_MAX)      target_in = POS_W'(POS_MAX);
        else if (int'(auto_target) < POS_MIN) target_in = POS_W'(POS_MIN);
        else                                  target_in = auto_target;
    end
`else
    logic unused_limits;
    assign unused_limits = (POS_MIN < POS_MAX);

    // Unbounded manual moves wrap modulo 2^POS_W.
    always_comb begin
        man_left  = x_position - STEP_V;
        man_right = x_position + STEP_V;
        target_in = auto_target;
    end
`endif

    servo_step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_change),
        .run  (timer_run),
        .tick (step_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_position <= POS_W'(POS_INIT);
            target     <= '0;
            auto_ack   <= 1'b0;
            auto_abort <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != IDLE);
            auto_ack   <= (state == SEEK) && (nxt == DONE);
            auto_abort <= (state == SEEK) && (nxt == IDLE);
            if (state == IDLE && nxt == SEEK) begin
                target <= target_in;
            end
            if (step_tick) begin
                case (state)
                    MAN_L:   x_position <= man_left;
                    MAN_R:   x_position <= man_right;
                    SEEK:    x_position <= (seek_dir == DIR_RIGHT) ? x_position + seek_step
                                                                   : x_position - seek_step;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_move_arbiter.sv
// Directed bench for servo_move_arbiter: step table for manual/seek timing plus hand-written corner sequences.
module tb_servo_move_arbiter;

`ifdef SERVO_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       manual;
    logic       sw1;
    logic       sw2;
    logic       auto_req;
    logic [7:0] auto_target;
    logic       auto_ack;
    logic       auto_abort;
    logic       busy;
    logic [7:0] x_position;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        string      name;
        logic       rst;
        logic       manual;
        logic       sw1;
        logic       sw2;
        logic       areq;
        logic [7:0] tgt;
        int         n;
        logic [7:0] ex;
        logic       eb;
        logic       ea;
        logic       eab;
    } vec_t;

    vec_t vecs[$];

    servo_move_arbiter #(
        .POS_W(8), .STEP(3), .STEP_TICKS(4), .POS_INIT(90), .POS_MIN(0), .POS_MAX(180)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .manual     (manual),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .auto_req   (auto_req),
        .auto_target(auto_target),
        .auto_ack   (auto_ack),
        .auto_abort (auto_abort),
        .busy       (busy),
        .x_position (x_position)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive(input logic r, input logic m, input logic s1, input logic s2,
                         input logic a, input logic [7:0] t);
        rst         = r;
        manual      = m;
        sw1         = s1;
        sw2         = s2;
        auto_req    = a;
        auto_target = t;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [7:0] ex, input logic eb,
                         input logic ea, input logic eab);
        n_vec++;
        if (x_position !== ex || busy !== eb || auto_ack !== ea || auto_abort !== eab) begin
            n_bad++;
            $display("FAIL %s: got x=%0d busy=%b ack=%b abort=%b, want x=%0d busy=%b ack=%b abort=%b",
                     name, x_position, busy, auto_ack, auto_abort, ex, eb, ea, eab);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic m, input logic s1,
                                input logic s2, input logic a, input logic [7:0] t, input int n,
                                input logic [7:0] ex, input logic eb, input logic ea,
                                input logic eab);
        vec_t v;
        v.name = name; v.rst = r; v.manual = m; v.sw1 = s1; v.sw2 = s2; v.areq = a;
        v.tgt = t; v.n = n; v.ex = ex; v.eb = eb; v.ea = ea; v.eab = eab;
        return v;
    endfunction

    // Reference seek: move toward the (clamped) target by at most 3 per step, recording each position.
    task automatic seek_and_check(input string name, input logic [7:0] start, input logic [7:0] tgt);
        logic [7:0] t;
        logic [7:0] p;
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] prev;
        bit         got_ack;
        bit         saw_abort;
        t = (LIM && tgt > 8'd180) ? 8'd180 : tgt;
        exp_q.delete();
        p = start;
        while (p != t) begin
            d = (t > p) ? t - p : p - t;
            if (d > 8'd3) d = 8'd3;
            p = (t > p) ? p + d : p - d;
            exp_q.push_back(p);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt);
        step(1);
        check({name, "_entry"}, start, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tgt);
        prev      = start;
        got_ack   = 1'b0;
        saw_abort = 1'b0;
        for (int i = 0; i < 600 && !got_ack; i++) begin
            step(1);
            saw_abort |= auto_abort;
            if (x_position != prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_step: got x=%0d, want no further step", name, x_position);
                end else begin
                    e = exp_q.pop_front();
                    if (x_position != e) begin
                        n_bad++;
                        $display("FAIL %s_step: got x=%0d, want x=%0d", name, x_position, e);
                    end
                end
                prev = x_position;
            end
            if (auto_ack) got_ack = 1'b1;
        end
        n_vec++;
        if (!got_ack) begin
            n_bad++;
            $display("FAIL %s_timeout: got no ack within 600 cycles, want ack", name);
        end
        n_vec++;
        if (exp_q.size() != 0 || x_position != t || saw_abort) begin
            n_bad++;
            $display("FAIL %s_end: got x=%0d pending=%0d abort_seen=%b, want x=%0d pending=0 abort_seen=0",
                     name, x_position, exp_q.size(), saw_abort, t);
        end
        step(1);
        check({name, "_idle"}, t, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Manual right, seek to 100, ignored auto_req, both switches
        vecs.push_back(mk("reset",            1,0,0,0,0,8'd0,  2, 8'd90, 0,0,0));
        vecs.push_back(mk("manR_entry",       0,1,0,1,0,8'd0,  1, 8'd90, 1,0,0));
        vecs.push_back(mk("manR_before_step", 0,1,0,1,0,8'd0,  3, 8'd90, 1,0,0));
        vecs.push_back(mk("manR_step1",       0,1,0,1,0,8'd0,  1, 8'd93, 1,0,0));
        vecs.push_back(mk("manR_step2",       0,1,0,1,0,8'd0,  4, 8'd96, 1,0,0));
        vecs.push_back(mk("manR_step3",       0,1,0,1,0,8'd0,  4, 8'd99, 1,0,0));
        vecs.push_back(mk("manR_release",     0,1,0,0,0,8'd0,  1, 8'd99, 0,0,0));
        vecs.push_back(mk("idle_hold",        0,1,0,0,0,8'd0,  2, 8'd99, 0,0,0));
        vecs.push_back(mk("reset2",           1,0,0,0,0,8'd0,  1, 8'd90, 0,0,0));
        vecs.push_back(mk("seek_entry",       0,0,0,0,1,8'd100,1, 8'd90, 1,0,0));
        vecs.push_back(mk("seek_wait",        0,0,0,0,0,8'd100,3, 8'd90, 1,0,0));
        vecs.push_back(mk("seek_93",          0,0,0,0,0,8'd100,1, 8'd93, 1,0,0));
        vecs.push_back(mk("seek_96",          0,0,0,0,0,8'd100,4, 8'd96, 1,0,0));
        vecs.push_back(mk("seek_99",          0,0,0,0,0,8'd100,4, 8'd99, 1,0,0));
        vecs.push_back(mk("seek_100",         0,0,0,0,0,8'd100,4, 8'd100,1,0,0));
        vecs.push_back(mk("done_ack",         0,0,0,0,0,8'd100,1, 8'd100,1,1,0));
        vecs.push_back(mk("ack_drop",         0,0,0,0,0,8'd100,1, 8'd100,0,0,0));
        vecs.push_back(mk("auto_ignored_man", 0,1,0,0,1,8'd50, 3, 8'd100,0,0,0));
        vecs.push_back(mk("both_switches",    0,1,1,1,0,8'd50, 3, 8'd100,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].manual, vecs[i].sw1, vecs[i].sw2, vecs[i].areq, vecs[i].tgt);
            step(vecs[i].n);
            check(vecs[i].name, vecs[i].ex, vecs[i].eb, vecs[i].ea, vecs[i].eab);
        end

        // Seek cancelled by manual after two steps
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1);
        check("abort_reset", 8'd90, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
        step(1);
        check("abort_seek_entry", 8'd90, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
        step(4);
        check("abort_seek_87", 8'd87, 1'b1, 1'b0, 1'b0);
        step(4);
        check("abort_seek_84", 8'd84, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        step(1);
        check("abort_pulse", 8'd84, 1'b0, 1'b0, 1'b1);
        step(1);
        check("abort_drop", 8'd84, 1'b0, 1'b0, 1'b0);

        // Walk to x=1, then manual left across zero and a direction swap mid-move
        seek_and_check("seek_to_1", 8'd84, 8'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1);
        check("manL_entry", 8'd1, 1'b1, 1'b0, 1'b0);
        step(3);
        check("manL_before_step", 8'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        check("manL_wrap1", LIM ? 8'd0 : 8'd254, 1'b1, 1'b0, 1'b0);
        step(4);
        check("manL_wrap2", LIM ? 8'd0 : 8'd251, 1'b1, 1'b0, 1'b0);
        step(2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1);
        check("swap_no_step", LIM ? 8'd0 : 8'd251, 1'b1, 1'b0, 1'b0);
        step(3);
        check("swap_wait", LIM ? 8'd0 : 8'd251, 1'b1, 1'b0, 1'b0);
        step(1);
        check("swap_step", LIM ? 8'd3 : 8'd254, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a seek, then a seek to an out-of-range target
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1);
        check("rst_before_seek", 8'd90, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd250);
        step(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd250);
        step(4);
        check("seek250_first", 8'd93, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd250);
        step(1);
        check("rst_mid_seek", 8'd90, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd250);
        step(2);
        check("rst_idle_hold", 8'd90, 1'b0, 1'b0, 1'b0);
        seek_and_check("seek_250", 8'd90, 8'd250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
